// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch stage of the multicycle RV32 core.
// Owns the PC, runs a req/ready read handshake with instruction memory,
// buffers the returned word and loads it into the instruction register.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (trap on misaligned branch
// targets instead of silently clearing the low address bits).
module instr_fetch_unit #(
    parameter int unsigned   PC_WIDTH = 32,
    parameter logic [31:0]   RESET_PC = 32'h0000_0000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                reset_wire,
    input  logic                fetch_req,
    input  logic                write_pc,
    input  logic                pc_sel,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                write_instruction,
    output logic [PC_WIDTH-1:0] mem_addr,
    output logic                mem_rd,
    input  logic [PC_WIDTH-1:0] mem_rdata,
    input  logic                mem_ready,
    output logic                busy,
    output logic                fetch_done,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] instr,
    output logic [6:0]          opcode,
    output logic [4:0]          rd,
    output logic [2:0]          funct3,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [6:0]          funct7,
    output logic                misaligned_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0] r_fbuf;
    logic [PC_WIDTH-1:0] w_pc_plus4;
    logic [PC_WIDTH-1:0] w_target_aligned;
    logic                w_in_req;
    logic                w_pc_wr_ok;

    assign w_in_req         = (r_state == REQ);
    assign w_pc_wr_ok       = write_pc && !w_in_req;
    assign w_pc_plus4       = r_pc + PC_WIDTH'(4);
    assign w_target_aligned = {branch_target[PC_WIDTH-1:2], 2'b00};

    // State register; reset_wire aborts any fetch in progress
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else if (reset_wire) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        mem_rd       = 1'b0;
        busy         = 1'b0;
        fetch_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (fetch_req) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                mem_rd = 1'b1;
                busy   = 1'b1;
                if (mem_ready) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                fetch_done   = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Fetch buffer captures read data on the completing REQ edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fbuf <= '0;
        end else if (reset_wire) begin
            r_fbuf <= '0;
        end else if (w_in_req && mem_ready) begin
            r_fbuf <= mem_rdata;
        end
    end

    // Instruction register loads from the buffer outside REQ
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_instr <= '0;
        end else if (reset_wire) begin
            r_instr <= '0;
        end else if (write_instruction && !w_in_req) begin
            r_instr <= r_fbuf;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_misaligned;

    // PC update; a misaligned branch target is refused and flagged
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc         <= PC_WIDTH'(RESET_PC);
            r_misaligned <= 1'b0;
        end else if (reset_wire) begin
            r_pc         <= PC_WIDTH'(RESET_PC);
            r_misaligned <= 1'b0;
        end else if (w_pc_wr_ok) begin
            if (!pc_sel) begin
                r_pc <= w_pc_plus4;
            end else if (branch_target[1:0] != 2'b00) begin
                r_misaligned <= 1'b1;
            end else begin
                r_pc <= branch_target;
            end
        end
    end

    assign misaligned_err = r_misaligned;
`else
    // PC update; branch targets are word-aligned by dropping the low bits
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc <= PC_WIDTH'(RESET_PC);
        end else if (reset_wire) begin
            r_pc <= PC_WIDTH'(RESET_PC);
        end else if (w_pc_wr_ok) begin
            r_pc <= pc_sel ? w_target_aligned : w_pc_plus4;
        end
    end

    assign misaligned_err = 1'b0;
`endif

    assign mem_addr = r_pc;
    assign pc       = r_pc;
    assign instr    = r_instr;
    assign opcode   = r_instr[6:0];
    assign rd       = r_instr[11:7];
    assign funct3   = r_instr[14:12];
    assign rs1      = r_instr[19:15];
    assign rs2      = r_instr[24:20];
    assign funct7   = r_instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of fetched words.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        reset_wire = 1'b0;
    logic        fetch_req = 1'b0;
    logic        write_pc = 1'b0;
    logic        pc_sel = 1'b0;
    logic [31:0] branch_target = '0;
    logic        write_instruction = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        busy;
    logic        fetch_done;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic        misaligned_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_word;
    logic [31:0] held_addr;
    logic [31:0] held_instr;

    instr_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .reset_wire(reset_wire), .fetch_req(fetch_req),
        .write_pc(write_pc), .pc_sel(pc_sel), .branch_target(branch_target),
        .write_instruction(write_instruction), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy),
        .fetch_done(fetch_done), .pc(pc), .instr(instr), .opcode(opcode), .rd(rd),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
        .misaligned_err(misaligned_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for fetch_done, pops the scoreboard, loads IR and checks it.
    task automatic finish_fetch(input string tag);
        int n = 0;
        while (fetch_done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, {31'd0, fetch_done}, 32'd1);
        if (fetch_done === 1'b1) begin
            if (sb_q.size() != 0) exp_word = sb_q.pop_front();
            else exp_word = 32'hXXXX_XXXX;
            write_instruction = 1'b1;
            tick();
            write_instruction = 1'b0;
            chk({tag, "_instr"}, instr, exp_word);
            chk({tag, "_done_pulse"}, {31'd0, fetch_done}, 32'd0);
        end
    endtask

    initial begin
        // Power-on reset
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_opcode", {25'd0, opcode}, 32'h0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, fetch_done}, 32'd0);
        chk("rst_mis", {31'd0, misaligned_err}, 32'd0);

        // Zero-wait fetch at PC 0: done in the third cycle after the request
        fetch_req = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h0050_0093;
        sb_q.push_back(32'h0050_0093);
        tick();
        fetch_req = 1'b0;
        chk("t1_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_addr", mem_addr, 32'h0);
        chk("t1_done_early", {31'd0, fetch_done}, 32'd0);
        tick();
        mem_ready = 1'b0;
        chk("t1_done_cycle3", {31'd0, fetch_done}, 32'd1);
        chk("t1_rd_drop", {31'd0, mem_rd}, 32'd0);
        finish_fetch("t1");
        chk("t1_opcode", {25'd0, opcode}, 32'h13);
        chk("t1_rd", {27'd0, rd}, 32'd1);
        chk("t1_rs1", {27'd0, rs1}, 32'd0);
        chk("t1_funct3", {29'd0, funct3}, 32'd0);

        // PC+4, then a fetch with 4 wait cycles and blocked writes inside REQ
        write_pc = 1'b1; pc_sel = 1'b0;
        tick();
        write_pc = 1'b0;
        chk("t2_pc4", pc, 32'h4);
        held_instr = instr;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        held_addr = 32'h4;
        for (int i = 0; i < 5; i++) begin
            chk("t2_mem_rd_held", {31'd0, mem_rd}, 32'd1);
            chk("t2_addr_stable", mem_addr, held_addr);
            if (i == 1) begin
                write_pc = 1'b1; pc_sel = 1'b1; branch_target = 32'h200;
                write_instruction = 1'b1;
            end else begin
                write_pc = 1'b0; write_instruction = 1'b0;
            end
            if (i == 4) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hFE20_8EE3;
                sb_q.push_back(32'hFE20_8EE3);
            end
            tick();
            if (i == 1) begin
                chk("t2_pc_blocked", pc, 32'h4);
                chk("t2_ir_blocked", instr, held_instr);
            end
        end
        mem_ready = 1'b0;
        chk("t2_rd_drop", {31'd0, mem_rd}, 32'd0);
        finish_fetch("t2");
        chk("t2_funct7", {25'd0, funct7}, 32'h7F);
        chk("t2_rs2", {27'd0, rs2}, 32'd2);
        chk("t2_rs1", {27'd0, rs1}, 32'd1);
        chk("t2_rd", {27'd0, rd}, 32'h1D);
        chk("t2_opcode", {25'd0, opcode}, 32'h63);

        // PC wrap at the top of the address space
        write_pc = 1'b1; pc_sel = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        chk("t3_pc_top", pc, 32'hFFFF_FFFC);
        pc_sel = 1'b0;
        tick();
        write_pc = 1'b0;
        chk("t3_pc_wrap", pc, 32'h0);

        // reset_wire aborts a REQ; the late mem_ready is ignored
        write_pc = 1'b1; pc_sel = 1'b1; branch_target = 32'h40;
        tick();
        write_pc = 1'b0;
        chk("t4_pc40", pc, 32'h40);
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("t4_req_addr", mem_addr, 32'h40);
        reset_wire = 1'b1;
        tick();
        reset_wire = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        chk("t4_busy_off", {31'd0, busy}, 32'd0);
        chk("t4_pc_reset", pc, 32'h0);
        chk("t4_ir_cleared", instr, 32'h0);
        tick();
        mem_ready = 1'b0;
        chk("t4_no_done", {31'd0, fetch_done}, 32'd0);
        chk("t4_mem_rd_off", {31'd0, mem_rd}, 32'd0);
        write_instruction = 1'b1;
        tick();
        write_instruction = 1'b0;
        chk("t4_buf_not_loaded", instr, 32'h0);
        chk("t4_no_done2", {31'd0, fetch_done}, 32'd0);

        // Misaligned branch target
        write_pc = 1'b1; pc_sel = 1'b1; branch_target = 32'h102;
        tick();
        write_pc = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("t5_pc_kept", pc, 32'h0);
        chk("t5_mis_set", {31'd0, misaligned_err}, 32'd1);
        tick();
        chk("t5_mis_sticky", {31'd0, misaligned_err}, 32'd1);
        reset_wire = 1'b1;
        tick();
        reset_wire = 1'b0;
        chk("t5_mis_clear", {31'd0, misaligned_err}, 32'd0);
`else
        chk("t5_pc_aligned", pc, 32'h100);
        chk("t5_mis_zero", {31'd0, misaligned_err}, 32'd0);
`endif

        // Branch and fetch on the same IDLE edge: fetch uses the new PC
        write_pc = 1'b1; pc_sel = 1'b1; branch_target = 32'h80;
        fetch_req = 1'b1;
        tick();
        write_pc = 1'b0; fetch_req = 1'b0;
        chk("t6_addr", mem_addr, 32'h80);
        chk("t6_mem_rd", {31'd0, mem_rd}, 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0013;
        sb_q.push_back(32'h0000_0013);
        tick();
        mem_ready = 1'b0;
        finish_fetch("t6");

        chk("sb_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
